modulo_monitor_nivel: RTL and testbench

- Parametrised, registered successor to the combinational minimum-value detector.
- Compares a WIDTH-bit level register against runtime-programmable minimum and maximum limits.
- Requires a condition to persist for HOLD_CYCLES consecutive enabled cycles before flagging it, and releases a flag only once the level has cleared the limit by HYST.
- Also raises a sticky alarm for the supervisory FSM; sits between the level register and the control/display logic.

---
 rtl/modulo_monitor_nivel.sv | 187 ++++++++++++++++++
 tb/tb_modulo_monitor_nivel.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/modulo_monitor_nivel.sv
// Registered level monitor: debounced min/max flags with release hysteresis,
// a sticky alarm for the supervisor, and a limit-consistency error flag.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// NORMAL    | level inside limits (or limits inconsistent), CNT = 0
// PEND_MIN  | level at/below LIM_MIN, counting consecutive enabled samples
// NIVEL_MIN | low flag active, waiting for level > LIM_MIN + HYST
// PEND_MAX  | level at/above LIM_MAX, counting consecutive enabled samples
// NIVEL_MAX | high flag active, waiting for level + HYST < LIM_MAX
module modulo_monitor_nivel #(
    parameter int WIDTH       = 7,
    parameter int HOLD_CYCLES = 3,
    parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] REG,
    input  logic [WIDTH-1:0] LIM_MIN,
    input  logic [WIDTH-1:0] LIM_MAX,
    input  logic [WIDTH-1:0] HYST,
    input  logic             CLR_ALARM,
    output logic             MIN,
    output logic             MAX,
    output logic             OK,
    output logic             ALARM,
    output logic             CFG_ERR,
    output logic [CW-1:0]    CNT
);

    typedef enum logic [2:0] {
        NORMAL    = 3'd0,
        PEND_MIN  = 3'd1,
        NIVEL_MIN = 3'd2,
        PEND_MAX  = 3'd3,
        NIVEL_MAX = 3'd4
    } state_t;

    localparam logic [CW:0] HOLD_LAST = (CW + 1)'(HOLD_CYCLES);

    state_t         state_q;
    state_t         state_n;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_n;
    logic [CW:0]    cnt_inc;
    logic           hold_done;

    logic [WIDTH:0] reg_e;
    logic [WIDTH:0] min_e;
    logic [WIDTH:0] max_e;
    logic [WIDTH:0] hyst_e;
    logic           below;
    logic           above;
    logic           rel_min;
    logic           rel_max;
    logic           cfg_bad;

    logic           min_n;
    logic           max_n;
    logic           ok_n;
    logic           entering;
    logic           alarm_n;

    // One extra bit so LIM_MIN + HYST and REG + HYST can never wrap.
    always_comb begin
        reg_e   = {1'b0, REG};
        min_e   = {1'b0, LIM_MIN};
        max_e   = {1'b0, LIM_MAX};
        hyst_e  = {1'b0, HYST};
        below   = (reg_e <= min_e);
        above   = (reg_e >= max_e);
        rel_min = (reg_e > (min_e + hyst_e));
        rel_max = ((reg_e + hyst_e) < max_e);
        cfg_bad = (LIM_MIN >= LIM_MAX);
    end

    always_comb begin
        cnt_inc   = {1'b0, cnt_q} + (CW + 1)'(1);
        hold_done = (cnt_inc == HOLD_LAST);
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = '0;
        if (cfg_bad) begin
            state_n = NORMAL;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (below) begin
                        if (HOLD_CYCLES == 1) begin
                            state_n = NIVEL_MIN;
                        end else begin
                            state_n = PEND_MIN;
                            cnt_n   = CW'(1);
                        end
                    end else if (above) begin
                        if (HOLD_CYCLES == 1) begin
                            state_n = NIVEL_MAX;
                        end else begin
                            state_n = PEND_MAX;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                PEND_MIN: begin
                    if (!below) begin
                        state_n = NORMAL;
                    end else if (hold_done) begin
                        state_n = NIVEL_MIN;
                    end else begin
                        cnt_n = cnt_inc[CW-1:0];
                    end
                end
                PEND_MAX: begin
                    if (!above) begin
                        state_n = NORMAL;
                    end else if (hold_done) begin
                        state_n = NIVEL_MAX;
                    end else begin
                        cnt_n = cnt_inc[CW-1:0];
                    end
                end
                NIVEL_MIN: begin
                    if (rel_min) begin
                        state_n = NORMAL;
                    end
                end
                NIVEL_MAX: begin
                    if (rel_max) begin
                        state_n = NORMAL;
                    end
                end
                default: begin
                    state_n = NORMAL;
                end
            endcase
        end
    end

    // Flags are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        min_n    = (state_n == NIVEL_MIN);
        max_n    = (state_n == NIVEL_MAX);
        ok_n     = !cfg_bad && ((state_n == NORMAL) || (state_n == PEND_MIN) ||
                                (state_n == PEND_MAX));
        entering = EN && (min_n || max_n) &&
                   (state_q != NIVEL_MIN) && (state_q != NIVEL_MAX);
        alarm_n  = ALARM;
        if (entering) begin
            alarm_n = 1'b1;
        end else if (CLR_ALARM) begin
            alarm_n = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            MIN     <= 1'b0;
            MAX     <= 1'b0;
            OK      <= 1'b1;
            CFG_ERR <= 1'b0;
        end else if (EN) begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            MIN     <= min_n;
            MAX     <= max_n;
            OK      <= ok_n;
            CFG_ERR <= cfg_bad;
        end
    end

    // Alarm clearing is deliberately not gated by EN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ALARM <= 1'b0;
        end else begin
            ALARM <= alarm_n;
        end
    end

    assign CNT = cnt_q;

endmodule

// File: tb/tb_modulo_monitor_nivel.sv
// Bench for modulo_monitor_nivel: hand-derived vector table through a scoreboard
// queue, plus an asynchronous mid-run reset sequence.
module tb_modulo_monitor_nivel;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic [6:0] REG = '0;
    logic [6:0] LIM_MIN = 7'd5;
    logic [6:0] LIM_MAX = 7'd100;
    logic [6:0] HYST = 7'd2;
    logic       CLR_ALARM = 1'b0;
    logic       MIN, MAX, OK, ALARM, CFG_ERR;
    logic [1:0] CNT;

    int n_cmp = 0;
    int n_err = 0;

    modulo_monitor_nivel #(.WIDTH(7), .HOLD_CYCLES(3)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .REG(REG), .LIM_MIN(LIM_MIN),
        .LIM_MAX(LIM_MAX), .HYST(HYST), .CLR_ALARM(CLR_ALARM),
        .MIN(MIN), .MAX(MAX), .OK(OK), .ALARM(ALARM), .CFG_ERR(CFG_ERR), .CNT(CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       en;
        logic [6:0] lv;
        logic [6:0] lmin;
        logic [6:0] lmax;
        logic [6:0] hy;
        logic       clr;
        logic       e_min;
        logic       e_max;
        logic       e_ok;
        logic       e_al;
        logic       e_cfg;
        logic [1:0] e_cnt;
    } vec_t;

    typedef struct {
        int         idx;
        logic       e_min;
        logic       e_max;
        logic       e_ok;
        logic       e_al;
        logic       e_cfg;
        logic [1:0] e_cnt;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic en, input int lv, input int lmin, input int lmax,
                                input int hy, input logic clr, input logic e_min,
                                input logic e_max, input logic e_ok, input logic e_al,
                                input logic e_cfg, input int e_cnt);
        vec_t v;
        v.en = en; v.lv = 7'(lv); v.lmin = 7'(lmin); v.lmax = 7'(lmax); v.hy = 7'(hy);
        v.clr = clr; v.e_min = e_min; v.e_max = e_max; v.e_ok = e_ok; v.e_al = e_al;
        v.e_cfg = e_cfg; v.e_cnt = 2'(e_cnt);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [1:0] act,
                         input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic e_min, input logic e_max,
                             input logic e_ok, input logic e_al, input logic e_cfg,
                             input logic [1:0] e_cnt);
        check("MIN", idx, {1'b0, MIN}, {1'b0, e_min});
        check("MAX", idx, {1'b0, MAX}, {1'b0, e_max});
        check("OK", idx, {1'b0, OK}, {1'b0, e_ok});
        check("ALARM", idx, {1'b0, ALARM}, {1'b0, e_al});
        check("CFG_ERR", idx, {1'b0, CFG_ERR}, {1'b0, e_cfg});
        check("CNT", idx, CNT, e_cnt);
    endtask

    // Drive one vector on the falling edge, queue its expectation, compare after the rising edge.
    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge CLK);
        EN = v.en; REG = v.lv; LIM_MIN = v.lmin; LIM_MAX = v.lmax; HYST = v.hy;
        CLR_ALARM = v.clr;
        e.idx = idx; e.e_min = v.e_min; e.e_max = v.e_max; e.e_ok = v.e_ok;
        e.e_al = v.e_al; e.e_cfg = v.e_cfg; e.e_cnt = v.e_cnt;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
        end else begin
            got = sb.pop_front();
            check_all(got.idx, got.e_min, got.e_max, got.e_ok, got.e_al, got.e_cfg, got.e_cnt);
        end
    endtask

    initial begin
        //           en  lv lmin lmax hy clr  min max ok al cfg cnt
        tv.push_back(mk(1,  50,  5, 100, 2, 0,  0, 0, 1, 0, 0, 0));  // 0
        tv.push_back(mk(1,   4,  5, 100, 2, 0,  0, 0, 1, 0, 0, 1));
        tv.push_back(mk(1,   4,  5, 100, 2, 0,  0, 0, 1, 0, 0, 2));
        tv.push_back(mk(1,   4,  5, 100, 2, 0,  1, 0, 0, 1, 0, 0));  // enter NIVEL_MIN
        tv.push_back(mk(1,   7,  5, 100, 2, 0,  1, 0, 0, 1, 0, 0));  // 7 <= 5+2 holds
        tv.push_back(mk(1,   8,  5, 100, 2, 0,  0, 0, 1, 1, 0, 0));  // released, alarm sticks
        tv.push_back(mk(1,  50,  5, 100, 2, 1,  0, 0, 1, 0, 0, 0));
        tv.push_back(mk(1,   4,  5, 100, 2, 0,  0, 0, 1, 0, 0, 1));
        tv.push_back(mk(1,   4,  5, 100, 2, 0,  0, 0, 1, 0, 0, 2));
        tv.push_back(mk(1,   9,  5, 100, 2, 0,  0, 0, 1, 0, 0, 0));  // persistence broken
        tv.push_back(mk(1,   5,  5, 100, 2, 0,  0, 0, 1, 0, 0, 1));  // REG == LIM_MIN counts
        tv.push_back(mk(1,   6,  5, 100, 2, 0,  0, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 100,  5, 100, 2, 0,  0, 0, 1, 0, 0, 1));  // 12
        tv.push_back(mk(1, 100,  5, 100, 2, 0,  0, 0, 1, 0, 0, 2));
        tv.push_back(mk(0,   0,  5, 100, 2, 0,  0, 0, 1, 0, 0, 2));  // frozen
        tv.push_back(mk(0,   0,  5, 100, 2, 0,  0, 0, 1, 0, 0, 2));
        tv.push_back(mk(0, 100,  5, 100, 2, 0,  0, 0, 1, 0, 0, 2));
        tv.push_back(mk(0,  50,  5, 100, 2, 0,  0, 0, 1, 0, 0, 2));
        tv.push_back(mk(1, 100,  5, 100, 2, 0,  0, 1, 0, 1, 0, 0));  // third enabled edge
        tv.push_back(mk(1,  98,  5, 100, 2, 0,  0, 1, 0, 1, 0, 0));  // 98+2 not < 100
        tv.push_back(mk(1,  98,  5, 100, 1, 0,  0, 0, 1, 1, 0, 0));  // 98+1 < 100 releases
        tv.push_back(mk(1, 120,  5, 100, 2, 0,  0, 0, 1, 1, 0, 1));
        tv.push_back(mk(1, 120,  5, 100, 2, 0,  0, 0, 1, 1, 0, 2));
        tv.push_back(mk(1, 120,  5, 100, 2, 1,  0, 1, 0, 1, 0, 0));  // entry beats clear
        tv.push_back(mk(1, 120,100, 100, 2, 0,  0, 0, 0, 1, 1, 0));  // 24: bad limits
        tv.push_back(mk(1, 120,100, 100, 2, 0,  0, 0, 0, 1, 1, 0));
        tv.push_back(mk(1,  50,  5, 100, 2, 0,  0, 0, 1, 1, 0, 0));
        tv.push_back(mk(1,  50,  5, 100, 2, 1,  0, 0, 1, 0, 0, 0));
        tv.push_back(mk(1,   0,  5, 100, 2, 0,  0, 0, 1, 0, 0, 1));
        tv.push_back(mk(1,   0,  5, 100, 2, 0,  0, 0, 1, 0, 0, 2));
        tv.push_back(mk(1,   0,  5, 100, 2, 1,  1, 0, 0, 1, 0, 0));  // 30: entry beats clear
        tv.push_back(mk(1,   0,  5, 100, 2, 0,  1, 0, 0, 1, 0, 0));
        tv.push_back(mk(0,  50,  5, 100, 2, 1,  1, 0, 0, 0, 0, 0));  // clear ignores EN
        tv.push_back(mk(1,   0,  5, 100, 2, 1,  1, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 127,  5, 100,127, 0, 1, 0, 0, 0, 0, 0));  // 5+127 unreachable
        tv.push_back(mk(1, 127,  5, 100, 2, 0,  0, 0, 1, 0, 0, 0));  // 35

        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_all(-1, 0, 0, 1, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            apply(i, tv[i]);
        end

        // Asynchronous reset from NIVEL_MIN with the alarm raised.
        apply(100, mk(1, 4, 5, 100, 2, 0, 0, 0, 1, 0, 0, 1));
        apply(101, mk(1, 4, 5, 100, 2, 0, 0, 0, 1, 0, 0, 2));
        apply(102, mk(1, 4, 5, 100, 2, 0, 1, 0, 0, 1, 0, 0));
        @(posedge CLK);
        #3;
        REG = 7'd50;
        RST = 1'b1;
        #1;
        check_all(103, 0, 0, 1, 0, 0, 0);
        @(posedge CLK);
        #1;
        check_all(104, 0, 0, 1, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        apply(105, mk(1, 50, 5, 100, 2, 0, 0, 0, 1, 0, 0, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard drain: got %0d leftover expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
